booth_seq: RTL and testbench
============================

BOOTH_SEQ -- requirements
Module: booth_seq

Interface
REQ-001 SHALL have parameter width, default 6, giving the operand width in bits (minimum 2).
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port start, input, 1 bit: request to begin a multiply; sampled only when busy=0.
REQ-005 SHALL have port in1, input, width bits: multiplicand, two's complement; sampled with an accepted start.
REQ-006 SHALL have port in2, input, width bits: multiplier, two's complement; sampled with an accepted start.
REQ-007 SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-008 SHALL have port done, output, 1 bit: one-cycle pulse when out is updated with a new product.
REQ-009 SHALL have port out, output, 2*width bits: signed product, registered, held between operations.

Function
REQ-010 SHALL implement FSM states IDLE and CALC, plus a registered done pulse.
REQ-011 SHALL accept start at a rising edge only when state=IDLE (busy=0).
  - Accepting start latches M = sign-extended in1 (width+1 bits).
  - Sets accumulator A = 0 (width+1 bits), Q = in2, Q_-1 = 0, step counter = 0.
  - Moves to CALC.
REQ-012 SHALL perform exactly one radix-2 Booth step per rising edge in CALC.
  - {Q[0],Q_-1}=01: A=A+M.
  - {Q[0],Q_-1}=10: A=A-M.
  - 00 or 11: A unchanged.
  - Then arithmetic right shift of {A,Q,Q_-1} by one, replicating the A sign bit.
  - Counter increments by 1.
REQ-013 SHALL keep A at width+1 bits so that in1 = -2^(width-1) produces no overflow; all add/sub are modulo 2^(width+1).
REQ-014 SHALL, on the edge performing step number width (counter = width-1):
  - Load out with the low 2*width bits of {A,Q} after that step's shift.
  - Set done=1 and return to IDLE.
REQ-015 SHALL define latency as follows:
  - Start accepted at edge E0.
  - done high and out valid in the cycle after edge E(width), i.e. width cycles after acceptance.
  - Default width=6: 6 cycles.
REQ-016 SHALL drive busy=1 exactly in CALC: from after E0 through edge E(width), where busy falls as done rises.
REQ-017 SHALL hold done for exactly one cycle, then clear it unless another completion occurs.
REQ-018 SHALL ignore start, in1 and in2 while busy=1; the operation in progress is unaffected.
REQ-019 SHALL accept a start asserted in the cycle done=1 (state IDLE), allowing back-to-back operations with no gap cycle.
REQ-020 SHALL hold out unchanged from one done to the next, including during a following operation.
REQ-021 SHALL produce out equal to the exact two's-complement product in1*in2 for all 2^(2*width) operand pairs.

Reset
REQ-022 SHALL, when rst=1 at a rising edge, regardless of state:
  - Set state=IDLE, busy=0, done=0, out=0.
  - Clear A, Q, Q_-1, M and the counter to 0.
REQ-023 SHALL give rst priority over start and over any Booth step in the same edge.
REQ-024 SHALL discard an operation interrupted by rst mid-operation, with no done pulse and out=0.
REQ-025 SHALL accept start at the first edge where rst=0 and state=IDLE.

Verification
REQ-026 SHALL cover basic multiply: width=6, in1=3, in2=5, start for one cycle -> busy for 6 cycles, done pulse one cycle, out=12'd15.
REQ-027 SHALL cover the extreme operands: in1=-32, in2=-32 -> out=12'h400 (1024); in1=-32, in2=31 -> out=12'hC20 (-992).
REQ-028 SHALL cover mixed sign: in1=-1, in2=31 -> out=12'hFE1 (-31); in1=7, in2=0 -> out=0, done still pulses after 6 cycles.
REQ-029 SHALL cover start while busy: start 3*5, reassert start with 2*2 at cycle 3 -> single done, out=15, no second done.
REQ-030 SHALL cover back-to-back: start 3*5, then start 4*-4 in the done cycle -> out=15 then, 6 cycles later, out=12'hFF0 (-16).
REQ-031 SHALL cover reset mid-operation: rst=1 at cycle 3 of an operation -> busy=0, done=0, out=0 next cycle; a new start then completes normally.

Source files
------------

// File: rtl/booth_seq.sv
// Sequential radix-2 Booth multiplier: one Booth step per cycle, registered product on out.
// Latency is width cycles from an accepted start; start/in1/in2 are ignored while busy.
module booth_seq #(
  parameter int width = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [width-1:0]     in1,
  input  logic [width-1:0]     in2,
  output logic                 busy,
  output logic                 done,
  output logic [2*width-1:0]   out
);

  localparam int CW = $clog2(width);
  localparam logic [CW-1:0] LAST_STEP = CW'(width - 1);

  typedef enum logic {IDLE, CALC} state_t;

  state_t              state_q, state_d;
  logic [width:0]      a_q, a_d;
  logic [width:0]      m_q, m_d;
  logic [width-1:0]    q_q, q_d;
  logic                qm1_q, qm1_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [2*width-1:0]  out_q, out_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;

  logic [width:0]      sum_a;
  logic [width:0]      sh_a;
  logic [width-1:0]    sh_q;

  always_comb begin
    // A is one bit wider than the operands so -2^(width-1) never overflows.
    unique case ({q_q[0], qm1_q})
      2'b01:   sum_a = a_q + m_q;
      2'b10:   sum_a = a_q - m_q;
      default: sum_a = a_q;
    endcase
    sh_a = {sum_a[width], sum_a[width:1]};
    sh_q = {sum_a[0], q_q[width-1:1]};
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    m_d     = m_q;
    q_d     = q_q;
    qm1_d   = qm1_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    done_d  = 1'b0;
    busy_d  = busy_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          m_d     = {in1[width-1], in1};
          a_d     = '0;
          q_d     = in2;
          qm1_d   = 1'b0;
          cnt_d   = '0;
          state_d = CALC;
          busy_d  = 1'b1;
        end
      end
      CALC: begin
        a_d   = sh_a;
        q_d   = sh_q;
        qm1_d = q_q[0];
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_STEP) begin
          out_d   = {sh_a[width-1:0], sh_q};
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      m_q     <= '0;
      q_q     <= '0;
      qm1_q   <= 1'b0;
      cnt_q   <= '0;
      out_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      m_q     <= m_d;
      q_q     <= q_d;
      qm1_q   <= qm1_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign out  = out_q;

endmodule

// File: tb/tb_booth_seq.sv
// Bench for booth_seq: directed corner operands plus random operands against an arithmetic product model.
module tb_booth_seq;
  localparam int W = 6;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [W-1:0]   in1, in2;
  logic           busy, done;
  logic [2*W-1:0] out;

  int checks   = 0;
  int failures = 0;

  booth_seq #(.width(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .in1  (in1),
    .in2  (in2),
    .busy (busy),
    .done (done),
    .out  (out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    int sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    return (2*W)'(sa * sb);
  endfunction

  // Waits for done, counting edges since the accepting edge; optionally drives noise on the inputs.
  task automatic wait_done(input bit noise, output int cycles);
    cycles = 0;
    while (done !== 1'b1 && cycles < 20) begin
      if (noise) begin
        start = 1'($urandom);
        in1   = W'($urandom);
        in2   = W'($urandom);
      end
      tick();
      cycles++;
    end
    start = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b, input bit noise);
    logic [2*W-1:0] prev, exp;
    int cyc;
    prev  = out;
    exp   = model(a, b);
    start = 1'b1;
    in1   = a;
    in2   = b;
    tick();
    start = 1'b0;
    check({tag, "_busy_after_accept"}, 32'(busy), 32'd1);
    check({tag, "_out_held"}, 32'(out), 32'(prev));
    wait_done(noise, cyc);
    check({tag, "_latency"}, cyc, W);
    check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    check({tag, "_product"}, 32'(out), 32'(exp));
    tick();
    check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
    check({tag, "_out_held_after"}, 32'(out), 32'(exp));
  endtask

  initial begin
    int cyc, ndone;
    logic [W-1:0] ra, rb;
    rst = 1'b1; start = 1'b0; in1 = '0; in2 = '0;
    tick();
    tick();
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_out",  32'(out),  32'd0);

    // First op right as reset deasserts.
    rst = 1'b0;
    run_op("basic_3x5", 6'd3, 6'd5, 1'b0);
    check("basic_3x5_value", 32'(out), 32'h00F);
    run_op("m32xm32", 6'b100000, 6'b100000, 1'b0);
    check("m32xm32_value", 32'(out), 32'h400);
    run_op("m32x31", 6'b100000, 6'd31, 1'b0);
    check("m32x31_value", 32'(out), 32'hC20);
    run_op("m1x31", 6'b111111, 6'd31, 1'b0);
    check("m1x31_value", 32'(out), 32'hFE1);
    run_op("7x0", 6'd7, 6'd0, 1'b0);

    // Start reasserted mid-operation must not disturb it or start a second op.
    start = 1'b1; in1 = 6'd3; in2 = 6'd5;
    tick();
    start = 1'b0;
    tick();
    tick();
    start = 1'b1; in1 = 6'd2; in2 = 6'd2;
    tick();
    start = 1'b0;
    wait_done(1'b0, cyc);
    check("busy_start_latency", cyc, W - 3);
    check("busy_start_product", 32'(out), 32'h00F);
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done) ndone++;
    end
    check("busy_start_no_second_done", ndone, 0);

    // Back-to-back: second start presented in the done cycle.
    start = 1'b1; in1 = 6'd3; in2 = 6'd5;
    tick();
    start = 1'b0;
    wait_done(1'b0, cyc);
    check("b2b_first_product", 32'(out), 32'h00F);
    start = 1'b1; in1 = 6'd4; in2 = 6'b111100;
    tick();
    start = 1'b0;
    check("b2b_second_accepted", 32'(busy), 32'd1);
    check("b2b_out_held", 32'(out), 32'h00F);
    wait_done(1'b0, cyc);
    check("b2b_second_latency", cyc, W);
    check("b2b_second_product", 32'(out), 32'hFF0);
    tick();

    // Reset mid-operation discards it.
    start = 1'b1; in1 = 6'd9; in2 = 6'd9;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_out",  32'(out),  32'd0);
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done) ndone++;
    end
    check("midrst_no_done", ndone, 0);
    run_op("after_rst", 6'd11, 6'b110011, 1'b0);

    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      run_op($sformatf("rand%0d", i), ra, rb, 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
